neural_network_udiv_seq: RTL
============================

// Module: neural_network_udiv_seq
// PURPOSE
//   Sequential unsigned restoring divider: the inverse of the pipelined 11x11->22 multiplier.
//   It divides a 22-bit product-width value by an 11-bit operand to give quotient and remainder.
//   It sits in the exact-dot-product datapath and rescales accumulated products back to operand scale.
//   Radix-2, one quotient bit per ce-enabled cycle, start/done handshake.
// PARAMETERS
//   DIVIDEND_WIDTH  22  dividend and quotient width
//   DIVISOR_WIDTH   11  divisor and remainder width
// PORTS
//   clk        in   1    clock, all state on rising edge
//   reset      in   1    synchronous, active-low reset
//   ce         in   1    clock enable; low freezes all state and outputs
//   start      in   1    request; sampled only when ce=1 and FSM is IDLE or DONE
//   dividend   in   DIVIDEND_WIDTH  numerator, captured on accepted start
//   divisor    in   DIVISOR_WIDTH   denominator, captured on accepted start
//   busy       out  1    1 while in CALC
//   done       out  1    one-cycle pulse (one ce-enabled cycle) when results become valid
//   quotient   out  DIVIDEND_WIDTH  result, held until next accepted start
//   remainder  out  DIVISOR_WIDTH   result, held until next accepted start
//   div_by_zero out 1    set with done when divisor==0, held with results
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low. reset=0 at any edge, regardless of ce:
//     FSM->IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. An operation in flight is discarded.
//   - FSM states: IDLE, CALC, DONE. All transitions require ce=1.
//     IDLE --start--> CALC (divisor!=0) or DONE (divisor==0).
//     CALC --bit counter reaches 0--> DONE.
//     DONE --> IDLE, unless start=1, in which case it goes to CALC/DONE as from IDLE (back-to-back).
//   - Accepted start loads q_sh=dividend, r_acc=0 (DIVISOR_WIDTH+1 bits), and d_reg=divisor.
//     It loads cnt=DIVIDEND_WIDTH-1.
//   - Each CALC cycle:
//     t = {r_acc[DIVISOR_WIDTH-1:0], q_sh[MSB]}.
//     If t >= d_reg: r_acc = t - d_reg and the new q bit is 1. Otherwise r_acc = t and the new q bit is 0.
//     q_sh = {q_sh[MSB-1:0], qbit}. Then cnt decrements.
//   - Latency: done=1 in the cycle after DIVIDEND_WIDTH ce-enabled CALC cycles.
//     That is DIVIDEND_WIDTH+1 ce-enabled edges after the start edge (23 by default).
//   - quotient, remainder and div_by_zero update on the same edge that raises done.
//     They do not change at any other time except reset.
//   - Divide by zero: no CALC. done rises on the edge after start, with quotient = all ones, remainder=0, div_by_zero=1.
//   - start while busy is ignored; no queueing, no error flag.
//   - ce=0 mid-CALC: state, counter and outputs hold. A done pulse spans every ce=0 cycle until the next ce=1 edge.
//   - Exactness: quotient*divisor + remainder == dividend and remainder < divisor, for all divisor != 0.
//   - No combinational path from inputs to outputs.
// STRUCTURE
//   - Shared package neural_network_div_pkg holds three items:
//     the DIVIDEND_WIDTH/DIVISOR_WIDTH defaults,
//     the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2),
//     and the counter width localparam $clog2(DIVIDEND_WIDTH).
//   - Sub-module neural_network_udiv_step is combinational.
//     Inputs: r_in, next dividend bit, d. Outputs: r_out, qbit. It is one restoring step, instantiated once.
//   - Top holds the FSM, counter, shift registers and output registers.
// TESTING
//   1. dividend=1000, divisor=7, start pulse -> done after 23 cycles; quotient=142, remainder=6, busy high 22 cycles.
//   2. dividend=4194303, divisor=2047 -> quotient=2049, remainder=0. Also dividend=0, divisor=5 -> quotient=0, remainder=0.
//   3. dividend=5, divisor=0 -> done on next cycle, div_by_zero=1, quotient=22'h3FFFFF, remainder=0.
//   4. Hold start=1 through CALC with new operands -> ignored.
//      start on the DONE cycle -> second op accepted, results correct (100/3 -> 33 r1).
//   5. Toggle ce=0 for 5 cycles mid-CALC (1000/7) -> done at 28 cycles, results unchanged. done holds while ce=0.
//   6. reset=0 at CALC cycle 10 -> next edge: busy=0, done=0, outputs 0. A fresh 1000/7 then completes correctly.
//   - Random: 10k random pairs checked against q*d+r==n and r<d.

Source files
------------

// File: rtl/neural_network_div_pkg.sv
// Shared defaults, FSM encoding and counter width for the sequential unsigned divider.
package neural_network_div_pkg;

    localparam int DIVIDEND_WIDTH_DEF = 22;
    localparam int DIVISOR_WIDTH_DEF  = 11;
    localparam int CNT_WIDTH_DEF      = $clog2(DIVIDEND_WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/neural_network_udiv_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the divisor if it fits.
module neural_network_udiv_step #(
    parameter int DW = 11
) (
    input  logic [DW:0]   r_in,
    input  logic          bit_in,
    input  logic [DW-1:0] d,
    output logic [DW:0]   r_out,
    output logic          qbit
);

    logic [DW+1:0] t;

    // r_in stays below d, so the top bit of t is always zero and the difference fits in DW+1 bits
    always_comb begin
        t     = {r_in, bit_in};
        qbit  = (t >= (DW+2)'(d));
        r_out = qbit ? (DW+1)'(t - (DW+2)'(d)) : (DW+1)'(t);
    end

endmodule

// File: rtl/neural_network_udiv_seq.sv
// Sequential unsigned restoring divider, one quotient bit per ce-enabled cycle.
// state | meaning
// IDLE  | waiting for start
// CALC  | shifting out one quotient bit per enabled cycle
// DONE  | results just became valid; done is high, a new start is accepted here
module neural_network_udiv_seq
    import neural_network_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
    parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH);

    div_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] q_sh_q, q_sh_d;
    logic [DIVIDEND_WIDTH-1:0] quot_q, quot_d;
    logic [DIVISOR_WIDTH:0]    r_acc_q, r_acc_d, r_step;
    logic [DIVISOR_WIDTH-1:0]  d_q, d_d;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic                      dbz_q, dbz_d;
    logic                      qbit;
    logic                      accept;
    logic                      div_zero;

    neural_network_udiv_step #(
        .DW(DIVISOR_WIDTH)
    ) u_step (
        .r_in  (r_acc_q),
        .bit_in(q_sh_q[DIVIDEND_WIDTH-1]),
        .d     (d_q),
        .r_out (r_step),
        .qbit  (qbit)
    );

    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign div_zero = (divisor == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = div_zero ? ST_DONE : ST_CALC;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CALC);
        done = (state_q == ST_DONE);
    end

    // Result registers only move on the edge that enters DONE
    always_comb begin
        cnt_d   = cnt_q;
        q_sh_d  = q_sh_q;
        r_acc_d = r_acc_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        if (accept) begin
            q_sh_d  = dividend;
            r_acc_d = '0;
            d_d     = divisor;
            cnt_d   = CNT_W'(DIVIDEND_WIDTH - 1);
            if (div_zero) begin
                quot_d = '1;
                rem_d  = '0;
                dbz_d  = 1'b1;
            end
        end else if (state_q == ST_CALC) begin
            q_sh_d  = {q_sh_q[DIVIDEND_WIDTH-2:0], qbit};
            r_acc_d = r_step;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                quot_d = {q_sh_q[DIVIDEND_WIDTH-2:0], qbit};
                rem_d  = r_step[DIVISOR_WIDTH-1:0];
                dbz_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            q_sh_q  <= '0;
            r_acc_q <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else if (ce) begin
            cnt_q   <= cnt_d;
            q_sh_q  <= q_sh_d;
            r_acc_q <= r_acc_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
